// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch + IF/ID register: 1-cycle latency; stall holds PC and IF/ID; imem wait inserts bubbles.
// Optional FETCH_MISALIGN_CHECK_EN adds a sticky misaligned-redirect flag on misalign_o.
module fetch_stage #(
  parameter int              N         = 64,
  parameter logic [N-1:0]    RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall_i,
  input  logic         PCSrc_i,
  input  logic [N-1:0] PCBranch_i,
  output logic         imem_req_o,
  output logic [N-1:0] imem_addr_o,
  input  logic [31:0]  imem_rdata_i,
  input  logic         imem_valid_i,
  output logic [31:0]  instr_o,
  output logic [N-1:0] pc_o,
  output logic         valid_o,
  output logic         misalign_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [N-1:0] PC_STEP    = N'(4);
  localparam logic [N-1:0] ALIGN_MASK = ~N'(3);

  state_t         state, state_nxt;
  logic [N-1:0]   pc, pc_nxt;
  logic [31:0]    instr_q, instr_nxt;
  logic [N-1:0]   pcq, pcq_nxt;
  logic           valid_q, valid_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcq     <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      instr_q <= instr_nxt;
      pcq     <= pcq_nxt;
      valid_q <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr_q;
    pcq_nxt   = pcq;
    valid_nxt = valid_q;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH, WAIT: begin
        if (PCSrc_i) begin
          // Redirect beats stall and drops any word returned this cycle.
          pc_nxt    = PCBranch_i & ALIGN_MASK;
          instr_nxt = NOP_INSTR;
          pcq_nxt   = '0;
          valid_nxt = 1'b0;
          state_nxt = FETCH;
        end else if (stall_i) begin
          state_nxt = state;
        end else if (!imem_valid_i) begin
          instr_nxt = NOP_INSTR;
          pcq_nxt   = '0;
          valid_nxt = 1'b0;
          state_nxt = WAIT;
        end else begin
          instr_nxt = imem_rdata_i;
          pcq_nxt   = pc;
          valid_nxt = 1'b1;
          pc_nxt    = pc + PC_STEP;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;
  logic misalign_set;

  always_comb begin
    misalign_set = 1'b0;
    if ((state == FETCH || state == WAIT) && PCSrc_i)
      misalign_set = |PCBranch_i[1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalign_q <= 1'b0;
    else        misalign_q <= misalign_q | misalign_set;
  end

  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  assign imem_addr_o = pc;
  assign imem_req_o  = (state == FETCH) || (state == WAIT);
  assign instr_o     = instr_q;
  assign pc_o        = pcq;
  assign valid_o     = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage against a rule-level fetch model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, PCSrc_i, imem_valid_i;
  logic [63:0] PCBranch_i;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [63:0] pc_o;
  logic        valid_o, misalign_o;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .PCSrc_i(PCSrc_i),
    .PCBranch_i(PCBranch_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rdata_i(imem_rdata_i), .imem_valid_i(imem_valid_i), .instr_o(instr_o),
    .pc_o(pc_o), .valid_o(valid_o), .misalign_o(misalign_o)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        valid;
    logic        req;
    logic [63:0] addr;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: what the fetch stage should look like after each edge.
  bit          m_started;
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic [63:0] m_pcq;
  bit          m_valid;
  bit          m_mis;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h8B02_0020;
    if (a == 64'h4) return 32'hCB03_0041;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_pc = 64'h0; m_instr = 32'h0; m_pcq = 64'h0; m_valid = 0; m_mis = 0;
  endtask

  // One cycle: drive inputs at the negedge slot, predict the post-edge view, then move on.
  task automatic cyc(input bit st, input bit ps, input logic [63:0] tgt, input bit iv);
    exp_t e;
    stall_i = st; PCSrc_i = ps; PCBranch_i = tgt; imem_valid_i = iv;
    imem_rdata_i = mem_word(m_pc);
    if (!m_started) begin
      m_started = 1;
    end else if (ps) begin
      m_pc = {tgt[63:2], 2'b00};
      m_instr = 32'h0; m_pcq = 64'h0; m_valid = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (tgt % 4 != 0) m_mis = 1;
`endif
    end else if (st) begin
      // everything holds
    end else if (!iv) begin
      m_instr = 32'h0; m_valid = 0;
    end else begin
      m_instr = mem_word(m_pc); m_pcq = m_pc; m_valid = 1; m_pc = m_pc + 64'd4;
    end
    e.instr = m_instr; e.pc = m_pcq; e.valid = m_valid;
    e.req = m_started; e.addr = m_pc; e.mis = m_mis;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Assert reset between edges, check it bites without a clock edge, release at a negedge slot.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    check("rst_instr", {32'h0, instr_o}, 64'h0);
    check("rst_pc", pc_o, 64'h0);
    check("rst_valid", {63'h0, valid_o}, 64'h0);
    check("rst_req", {63'h0, imem_req_o}, 64'h0);
    check("rst_addr", imem_addr_o, 64'h0);
    check("rst_mis", {63'h0, misalign_o}, 64'h0);
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("instr", {32'h0, instr_o}, {32'h0, e.instr});
        check("valid", {63'h0, valid_o}, {63'h0, e.valid});
        if (e.valid) check("pc", pc_o, e.pc);
        check("req", {63'h0, imem_req_o}, {63'h0, e.req});
        check("addr", imem_addr_o, e.addr);
        check("misalign", {63'h0, misalign_o}, {63'h0, e.mis});
      end
    end
  end

  initial begin : stim
    logic [63:0] tgt;
    bit st, ps, iv;
    reset = 1'b0; stall_i = 0; PCSrc_i = 0; imem_valid_i = 0;
    PCBranch_i = '0; imem_rdata_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Startup: idle cycle, then 0 and 4 accepted.
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    // Stall 3 cycles at PC 8 (with an imem wait mixed in: stall wins).
    cyc(1, 0, 0, 1); cyc(1, 0, 0, 0); cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    // Two wait states at PC 12.
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 1);
    // Redirect beats stall and imem valid.
    cyc(1, 1, 64'h40, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    // Misaligned redirect.
    cyc(0, 1, 64'h42, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    // PC wrap at the top of the address space.
    cyc(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    repeat (6) cyc(0, 0, 0, 1);
    // PC now 0x1C: reset mid-stream, then fetch restarts at 0.
    do_reset();
    cyc(1, 1, 64'h80, 1);  // redirect during idle is ignored
    repeat (3) cyc(0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        ps = ($urandom_range(0, 99) < 5);
        st = ($urandom_range(0, 99) < 20);
        iv = ($urandom_range(0, 99) < 75);
        tgt = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 0) tgt = {52'h0, tgt[11:0]};
        cyc(st, ps, tgt, iv);
      end
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
